// File: rtl/rbi_mem_l2_mmio_if.sv
// MMIO bus between the ring bridge (master) and the MMIO device side (slave).
interface rbi_mem_l2_mmio_if;
  logic [31:0] mmioAddr;
  logic [4:0]  mmioOpm;
  logic [63:0] mmioOutData;
  logic [63:0] mmioInData;
  logic [1:0]  mmioOK;
  logic [63:0] mmioExcIn;

  modport master (
    output mmioAddr, mmioOpm, mmioOutData,
    input  mmioInData, mmioOK, mmioExcIn
  );

  modport slave (
    input  mmioAddr, mmioOpm, mmioOutData,
    output mmioInData, mmioOK, mmioExcIn
  );
endinterface

// File: rtl/rbi_mem_l2_mmio.sv
// L2 ring MMIO bridge node: claims MMIO load/store requests, runs one bus cycle,
// and re-inserts the response into the first free ring slot; everything else is forwarded.
module rbi_mem_l2_mmio #(
  parameter int TIMEOUT = 4096
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [47:0]  memAddrIn,
  output logic [47:0]  memAddrOut,
  input  logic [127:0] memDataIn,
  output logic [127:0] memDataOut,
  input  logic [15:0]  memOpmIn,
  output logic [15:0]  memOpmOut,
  input  logic [15:0]  memSeqIn,
  output logic [15:0]  memSeqOut,
  input  logic [7:0]   unitNodeId,
  rbi_mem_l2_mmio_if.master mmio
);

  typedef enum logic [1:0] {IDLE, ACCESS, RELEASE, RESPOND} state_t;

  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] T_LAST = CW'(TIMEOUT - 1);

  state_t state, stateNext;

  logic [15:0]  seqReg;
  logic [15:0]  opmReg;
  logic [47:0]  addrReg;
  logic [63:0]  dataReg;
  logic         respFault;
  logic [CW-1:0] timeoutCnt;

  logic [15:0]  opmNext;
  logic [15:0]  seqNext;
  logic [47:0]  addrNext;
  logic [127:0] dataNext;

  logic isMmioOp, isMmioAddr, isMmioReq;
  logic busDone, busFault, timedOut, slotFree;

  assign isMmioOp   = (memOpmIn[7:4] == 4'h9) || (memOpmIn[7:4] == 4'hA);
  assign isMmioAddr = (memAddrIn[47:32] == 16'h0) && (memAddrIn[31:28] == 4'hF);
  assign isMmioReq  = isMmioOp && isMmioAddr;
  assign busDone    = (mmio.mmioOK == 2'b01);
  assign busFault   = (mmio.mmioOK == 2'b11);
  assign timedOut   = (timeoutCnt == T_LAST);
  assign slotFree   = (memOpmIn[7:0] == 8'h00);

  // Node id is not needed for decode; responses route back by the latched seq.
  wire unusedBits = &{1'b0, unitNodeId, opmReg[7:6], opmReg[3]};

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (isMmioReq) stateNext = ACCESS;
      ACCESS:  if (busDone || busFault || timedOut) stateNext = RELEASE;
      RELEASE: if (mmio.mmioOK == 2'b00) stateNext = RESPOND;
      RESPOND: if (slotFree) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_comb begin
    opmNext          = memOpmIn;
    seqNext          = memSeqIn;
    addrNext         = memAddrIn;
    dataNext         = memDataIn;
    mmio.mmioOpm     = 5'd0;
    mmio.mmioAddr    = 32'd0;
    mmio.mmioOutData = 64'd0;
    case (state)
      IDLE: begin
        if (isMmioReq) begin
          // The claimed request leaves an empty slot behind it.
          opmNext  = 16'h0;
          seqNext  = 16'h0;
          addrNext = 48'h0;
          dataNext = 128'h0;
        end
      end
      ACCESS: begin
        mmio.mmioOpm     = {opmReg[5], opmReg[4], opmReg[2:0]};
        mmio.mmioAddr    = addrReg[31:0];
        mmio.mmioOutData = dataReg;
      end
      RESPOND: begin
        if (slotFree) begin
          opmNext  = {opmReg[15:8], 3'b011, respFault, 1'b0, opmReg[2:0]};
          seqNext  = seqReg;
          addrNext = addrReg;
          dataNext = {64'h0, dataReg};
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      memOpmOut  <= 16'h0;
      memSeqOut  <= 16'h0;
      memAddrOut <= 48'h0;
      memDataOut <= 128'h0;
    end else begin
      memOpmOut  <= opmNext;
      memSeqOut  <= seqNext;
      memAddrOut <= addrNext;
      memDataOut <= dataNext;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      seqReg     <= 16'h0;
      opmReg     <= 16'h0;
      addrReg    <= 48'h0;
      dataReg    <= 64'h0;
      respFault  <= 1'b0;
      timeoutCnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          timeoutCnt <= '0;
          respFault  <= 1'b0;
          if (isMmioReq) begin
            seqReg  <= memSeqIn;
            opmReg  <= memOpmIn;
            addrReg <= memAddrIn;
            dataReg <= memDataIn[63:0];
          end
        end
        ACCESS: begin
          if (busFault) begin
            dataReg   <= mmio.mmioExcIn;
            respFault <= 1'b1;
          end else if (busDone) begin
            // Stores report success with zero data.
            dataReg   <= opmReg[4] ? mmio.mmioInData : 64'h0;
            respFault <= 1'b0;
          end else if (timedOut) begin
            dataReg   <= 64'h0;
            respFault <= 1'b1;
          end else begin
            timeoutCnt <= timeoutCnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rbi_mem_l2_mmio.sv
// Directed bench for the L2 ring MMIO bridge: forwarding table plus hand-written bus sequences.
module tb_rbi_mem_l2_mmio;

  logic         clock = 1'b0;
  logic         reset;
  logic [47:0]  memAddrIn, memAddrOut;
  logic [127:0] memDataIn, memDataOut;
  logic [15:0]  memOpmIn, memOpmOut;
  logic [15:0]  memSeqIn, memSeqOut;
  logic [7:0]   unitNodeId;

  rbi_mem_l2_mmio_if bus();

  rbi_mem_l2_mmio dut (
    .clock(clock), .reset(reset),
    .memAddrIn(memAddrIn), .memAddrOut(memAddrOut),
    .memDataIn(memDataIn), .memDataOut(memDataOut),
    .memOpmIn(memOpmIn), .memOpmOut(memOpmOut),
    .memSeqIn(memSeqIn), .memSeqOut(memSeqOut),
    .unitNodeId(unitNodeId),
    .mmio(bus)
  );

  always #5 clock = ~clock;

  typedef struct {
    string        name;
    logic [15:0]  opm;
    logic [15:0]  seq;
    logic [47:0]  addr;
    logic [127:0] data;
    logic [15:0]  expOpm;
    logic [15:0]  expSeq;
    logic [47:0]  expAddr;
    logic [127:0] expData;
  } vec_t;

  int vecCount  = 0;
  int missCount = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    vecCount++;
    if (act !== exp) begin
      missCount++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [15:0] opm, input logic [15:0] seq,
                       input logic [47:0] addr, input logic [127:0] data);
    memOpmIn  = opm;
    memSeqIn  = seq;
    memAddrIn = addr;
    memDataIn = data;
  endtask

  task automatic idleIn();
    drive(16'h0, 16'h0, 48'h0, 128'h0);
  endtask

  vec_t vecs [7];
  int   active;

  initial begin
    vecs[0] = '{"fwd_plain",   16'h0040, 16'h1234, 48'h0,             128'h0,
                16'h0040, 16'h1234, 48'h0, 128'h0};
    vecs[1] = '{"fwd_idle",    16'h0000, 16'hBEEF, 48'h0000_F000_0000, 128'h5,
                16'h0000, 16'hBEEF, 48'h0000_F000_0000, 128'h5};
    vecs[2] = '{"fwd_resp",    16'h0062, 16'h1105, 48'h0000_F000_E010, 128'hDEADBEEF,
                16'h0062, 16'h1105, 48'h0000_F000_E010, 128'hDEADBEEF};
    vecs[3] = '{"fwd_notf",    16'h0092, 16'h2001, 48'h0000_E000_0010, 128'h77,
                16'h0092, 16'h2001, 48'h0000_E000_0010, 128'h77};
    vecs[4] = '{"fwd_hiaddr",  16'h00A3, 16'h2002, 48'h0001_F000_0000, {64'h1, 64'h2},
                16'h00A3, 16'h2002, 48'h0001_F000_0000, {64'h1, 64'h2}};
    vecs[5] = '{"fwd_opB",     16'h00B2, 16'h2003, 48'h0000_F000_0040, 128'h9,
                16'h00B2, 16'h2003, 48'h0000_F000_0040, 128'h9};
    vecs[6] = '{"fwd_flags",   16'hFF80, 16'h2004, 48'h0000_F000_0080, 128'hA,
                16'hFF80, 16'h2004, 48'h0000_F000_0080, 128'hA};

    unitNodeId       = 8'h86;
    bus.mmioOK       = 2'b00;
    bus.mmioInData   = 64'h0;
    bus.mmioExcIn    = 64'h0;

    // Reset with an MMIO request on the ring: it must not be claimed.
    reset = 1'b1;
    drive(16'h0092, 16'h1105, 48'h0000_F000_E010, 128'hFFFF);
    step();
    step();
    chk("rst_opm",  memOpmOut,  16'h0);
    chk("rst_seq",  memSeqOut,  16'h0);
    chk("rst_addr", memAddrOut, 48'h0);
    chk("rst_data", memDataOut, 128'h0);
    chk("rst_mopm", bus.mmioOpm, 5'h0);
    chk("rst_madr", bus.mmioAddr, 32'h0);
    chk("rst_mdat", bus.mmioOutData, 64'h0);
    idleIn();
    reset = 1'b0;
    step();
    $display("reset check done");

    for (int i = 0; i < 7; i++) begin
      drive(vecs[i].opm, vecs[i].seq, vecs[i].addr, vecs[i].data);
      step();
      chk({vecs[i].name, "_opm"},  memOpmOut,  vecs[i].expOpm);
      chk({vecs[i].name, "_seq"},  memSeqOut,  vecs[i].expSeq);
      chk({vecs[i].name, "_addr"}, memAddrOut, vecs[i].expAddr);
      chk({vecs[i].name, "_data"}, memDataOut, vecs[i].expData);
      chk({vecs[i].name, "_mopm"}, bus.mmioOpm, 5'h0);
      $display("vec %0d %s opm=%h seq=%h", i, vecs[i].name, memOpmOut, memSeqOut);
    end
    idleIn();
    step();

    // MMIO load with a hold cycle.
    drive(16'hAB92, 16'h1105, 48'h0000_F000_E010, 128'h1111);
    step();
    chk("ld_slot_opm", memOpmOut, 16'h0);
    chk("ld_slot_seq", memSeqOut, 16'h0);
    chk("ld_mopm", bus.mmioOpm, 5'b01010);
    chk("ld_madr", bus.mmioAddr, 32'hF000E010);
    idleIn();
    bus.mmioOK = 2'b10;
    step();
    chk("ld_hold", bus.mmioOpm, 5'b01010);
    bus.mmioOK = 2'b01;
    bus.mmioInData = 64'hDEADBEEF;
    step();
    chk("ld_rel_mopm", bus.mmioOpm, 5'h0);
    step();
    chk("ld_rel_wait", memOpmOut, 16'h0);
    bus.mmioOK = 2'b00;
    bus.mmioInData = 64'h0;
    step();
    step();
    chk("ld_resp_opm",  memOpmOut,  16'hAB62);
    chk("ld_resp_seq",  memSeqOut,  16'h1105);
    chk("ld_resp_addr", memAddrOut, 48'h0000_F000_E010);
    chk("ld_resp_data", memDataOut, 128'hDEADBEEF);
    step();
    chk("ld_after", memOpmOut, 16'h0);
    $display("load seq=%h done", 16'h1105);

    // MMIO store.
    drive(16'h00A3, 16'h2207, 48'h0000_F000_0008, {64'hFFFF, 64'h0123456789ABCDEF});
    step();
    idleIn();
    chk("st_mopm", bus.mmioOpm, 5'b10011);
    chk("st_mdat", bus.mmioOutData, 64'h0123456789ABCDEF);
    chk("st_madr", bus.mmioAddr, 32'hF0000008);
    bus.mmioOK = 2'b01;
    bus.mmioInData = 64'h5555;
    step();
    bus.mmioOK = 2'b00;
    step();
    step();
    chk("st_resp_opm",  memOpmOut,  16'h0063);
    chk("st_resp_seq",  memSeqOut,  16'h2207);
    chk("st_resp_data", memDataOut, 128'h0);
    $display("store seq=%h done", 16'h2207);

    // Fault from the device.
    drive(16'h0091, 16'h3301, 48'h0000_F000_0100, 128'h0);
    step();
    idleIn();
    bus.mmioOK = 2'b11;
    bus.mmioExcIn = 64'h8003;
    step();
    bus.mmioOK = 2'b00;
    bus.mmioExcIn = 64'h0;
    step();
    step();
    chk("flt_resp_opm",  memOpmOut,  16'h0071);
    chk("flt_resp_seq",  memSeqOut,  16'h3301);
    chk("flt_resp_data", memDataOut, 128'h8003);
    $display("fault seq=%h done", 16'h3301);

    // Busy: second request forwarded, response waits for a free slot.
    drive(16'h0090, 16'h4400, 48'h0000_F000_0020, 128'h0);
    step();
    drive(16'h0093, 16'h4401, 48'h0000_F000_0030, 128'h55);
    step();
    chk("busy_fwd_opm",  memOpmOut,  16'h0093);
    chk("busy_fwd_seq",  memSeqOut,  16'h4401);
    chk("busy_fwd_data", memDataOut, 128'h55);
    chk("busy_madr", bus.mmioAddr, 32'hF0000020);
    chk("busy_mopm", bus.mmioOpm, 5'b01000);
    idleIn();
    bus.mmioOK = 2'b01;
    bus.mmioInData = 64'hAA;
    step();
    bus.mmioOK = 2'b00;
    step();
    for (int i = 0; i < 3; i++) begin
      drive(16'h0040, 16'h7000 + 16'(i), 48'h0, 128'h0);
      step();
      chk("busy_traffic_opm", memOpmOut, 16'h0040);
      chk("busy_traffic_seq", memSeqOut, 16'h7000 + 16'(i));
    end
    idleIn();
    step();
    chk("busy_resp_opm",  memOpmOut,  16'h0060);
    chk("busy_resp_seq",  memSeqOut,  16'h4400);
    chk("busy_resp_addr", memAddrOut, 48'h0000_F000_0020);
    chk("busy_resp_data", memDataOut, 128'hAA);
    $display("busy seq=%h done", 16'h4400);

    // Timeout: device holds forever.
    drive(16'h0093, 16'h5501, 48'h0000_F000_0200, 128'h0);
    bus.mmioOK = 2'b10;
    bus.mmioInData = 64'h1234;
    step();
    idleIn();
    active = 0;
    for (int i = 0; i < 5000 && bus.mmioOpm != 5'h0; i++) begin
      active++;
      step();
    end
    chk("to_cycles", 128'(active), 128'd4096);
    bus.mmioOK = 2'b00;
    step();
    step();
    chk("to_resp_opm",  memOpmOut,  16'h0073);
    chk("to_resp_seq",  memSeqOut,  16'h5501);
    chk("to_resp_data", memDataOut, 128'h0);
    $display("timeout seq=%h done after %0d cycles", 16'h5501, active);

    // Reset during ACCESS abandons the transaction.
    drive(16'h0092, 16'h6601, 48'h0000_F000_0300, 128'h0);
    step();
    chk("rsta_mopm_pre", bus.mmioOpm, 5'b01010);
    reset = 1'b1;
    drive(16'h0040, 16'h6602, 48'h0, 128'h0);
    step();
    chk("rsta_mopm", bus.mmioOpm, 5'h0);
    chk("rsta_opm",  memOpmOut, 16'h0);
    reset = 1'b0;
    idleIn();
    bus.mmioOK = 2'b01;
    bus.mmioInData = 64'h99;
    step();
    bus.mmioOK = 2'b00;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("rsta_noresp", memOpmOut, 16'h0);
    end
    $display("reset-in-access seq=%h done", 16'h6601);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
